// File: rtl/jesd204_rx_lane_sync_if.sv
// -----------------------------------------------------------------------------
// jesd204_rx_lane_sync_if
// Bundle of the per-lane PHY receive signals that feed jesd204_rx_lane_sync.
//   phy_data        DATA_PATH_WIDTH*8  8b/10b-decoded octets, octet 0 in [7:0]
//   phy_charisk     DATA_PATH_WIDTH    per-octet K flag
//   phy_notintable  DATA_PATH_WIDTH    per-octet not-in-table error
//   phy_disperr     DATA_PATH_WIDTH    per-octet disparity error
// Modports: master = PHY side (drives), slave = lane sync side (receives).
// -----------------------------------------------------------------------------
interface jesd204_rx_lane_sync_if #(
    parameter int DATA_PATH_WIDTH = 4
);
    logic [DATA_PATH_WIDTH*8-1:0] phy_data;
    logic [DATA_PATH_WIDTH-1:0]   phy_charisk;
    logic [DATA_PATH_WIDTH-1:0]   phy_notintable;
    logic [DATA_PATH_WIDTH-1:0]   phy_disperr;

    modport master (output phy_data, phy_charisk, phy_notintable, phy_disperr);
    modport slave  (input  phy_data, phy_charisk, phy_notintable, phy_disperr);
endinterface

// File: rtl/jesd204_rx_lane_sync.sv
// -----------------------------------------------------------------------------
// jesd204_rx_lane_sync
// Per-lane JESD204B receive front end: code-group synchronization with a
// character-error monitor, ILAS extraction, descrambling (1+x^14+x^15) and
// restore of replaced /F/ and /A/ characters when scrambling is disabled.
//
// Ports
//   clk                       lane/link clock
//   resetn                    synchronous active-low reset
//   phy                       PHY octets, K flags and error flags (slave)
//   cfg_octets_per_frame      F-1
//   cfg_beats_per_multiframe  beats per multiframe minus 1
//   cfg_disable_scrambler     1 = bypass descrambler, enable character restore
//   ilas_data / ilas_valid    raw ILAS octets, 2 cycles after the PHY
//   rx_data / rx_valid        user data, 2 cycles after the PHY
//   status_state              0=INIT 1=CHECK 2=ILAS 3=DATA (registered state)
//   status_resync             one-cycle pulse on any fall back to INIT
//   status_err_count          saturating count of erroring octets
//                             (only when JESD204_RX_LANE_ERR_CNT_EN is defined)
//
// DATA_PATH_WIDTH is expected to be a power of two of at least 2.
// -----------------------------------------------------------------------------
module jesd204_rx_lane_sync #(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    jesd204_rx_lane_sync_if.slave        phy,
    input  logic [7:0]                   cfg_octets_per_frame,
    input  logic [7:0]                   cfg_beats_per_multiframe,
    input  logic                         cfg_disable_scrambler,
    output logic [DATA_PATH_WIDTH*8-1:0] ilas_data,
    output logic                         ilas_valid,
    output logic [DATA_PATH_WIDTH*8-1:0] rx_data,
    output logic                         rx_valid,
    output logic [1:0]                   status_state,
`ifdef JESD204_RX_LANE_ERR_CNT_EN
    output logic [31:0]                  status_err_count,
`endif
    output logic                         status_resync
);
    localparam int DW = DATA_PATH_WIDTH * 8;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ILAS  = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    // Place octet 0 in the top byte so the serial bit order (octet 0 MSB
    // first) runs from the highest index downwards.
    function automatic logic [DW-1:0] octet_swap(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_PATH_WIDTH; i++)
            r[DW-1-8*i -: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Wide self-synchronizing descrambler; s[0] is the most recent received bit.
    function automatic logic [DW-1:0] descramble(input logic [DW-1:0] w, input logic [14:0] s);
        logic [DW+14:0] e;
        logic [DW-1:0]  o;
        e = {s, w};
        for (int p = 0; p < DW; p++)
            o[p] = e[p] ^ e[p+14] ^ e[p+15];
        return o;
    endfunction

    state_t                     state, state_next;
    logic [1:0]                 k_cnt, k_cnt_next;
    logic [1:0]                 err_cnt, err_next;
    logic [1:0]                 clean_cnt, clean_next;
    logic [7:0]                 mf_pos, mf_pos_next, mf_pos_cur;
    logic [1:0]                 mf_num, mf_num_next, mf_num_cur;
    logic                       ilas_beat, data_beat, keep_link;

    logic [DATA_PATH_WIDTH-1:0] oct_err;
    logic                       beat_err, k_beat, r_start, a_end;

    logic [14:0]                scr_state;
    logic [DW-1:0]              scr_w, desc_data, rest_data;
    logic [7:0]                 fpos, fpos_next, last_eof, eof_run;
    logic                       small_f;

    logic                       vld_ilas_p0, vld_data_p0;
    logic [DW-1:0]              ilas_data_p0, rx_data_p0;

    assign oct_err  = phy.phy_notintable | phy.phy_disperr;
    assign beat_err = |oct_err;
    assign r_start  = phy.phy_charisk[0] && (phy.phy_data[7:0] == 8'h1C);
    assign a_end    = phy.phy_charisk[DATA_PATH_WIDTH-1] && (phy.phy_data[DW-1 -: 8] == 8'h7C);

    always_comb begin
        k_beat = !beat_err;
        for (int i = 0; i < DATA_PATH_WIDTH; i++)
            if (!phy.phy_charisk[i] || (phy.phy_data[8*i +: 8] != 8'hBC))
                k_beat = 1'b0;
    end

    // The /R/ beat seen in CHECK is ILAS beat 0 of multiframe 0.
    assign mf_pos_cur = (state == ST_CHECK) ? 8'd0 : mf_pos;
    assign mf_num_cur = (state == ST_CHECK) ? 2'd0 : mf_num;

    always_comb begin
        state_next  = state;
        k_cnt_next  = k_cnt;
        err_next    = err_cnt;
        clean_next  = clean_cnt;
        mf_pos_next = mf_pos;
        mf_num_next = mf_num;
        ilas_beat   = 1'b0;
        data_beat   = 1'b0;

        if (state != ST_INIT) begin
            if (beat_err) begin
                err_next   = err_cnt + 2'd1;
                clean_next = 2'd0;
            end else if (clean_cnt == 2'd3) begin
                err_next   = 2'd0;
                clean_next = 2'd0;
            end else begin
                clean_next = clean_cnt + 2'd1;
            end
        end

        case (state)
            ST_INIT: begin
                if (!k_beat) begin
                    k_cnt_next = 2'd0;
                end else if (k_cnt == 2'd3) begin
                    k_cnt_next = 2'd0;
                    state_next = ST_CHECK;
                end else begin
                    k_cnt_next = k_cnt + 2'd1;
                end
            end
            ST_CHECK: begin
                if (!k_beat && !beat_err) begin
                    if (r_start) begin
                        state_next = ST_ILAS;
                        ilas_beat  = 1'b1;
                    end else begin
                        state_next = ST_INIT;
                    end
                end
            end
            ST_ILAS: ilas_beat = 1'b1;
            default: data_beat = 1'b1;
        endcase

        if (ilas_beat) begin
            if (mf_pos_cur == cfg_beats_per_multiframe) begin
                mf_pos_next = 8'd0;
                mf_num_next = mf_num_cur + 2'd1;
                if (!a_end)
                    state_next = ST_INIT;
                else if (mf_num_cur == 2'd3)
                    state_next = ST_DATA;
            end else begin
                mf_pos_next = mf_pos_cur + 8'd1;
                mf_num_next = mf_num_cur;
            end
        end

        if ((state != ST_INIT) && (err_next == 2'd3))
            state_next = ST_INIT;

        if (state_next != ST_ILAS) begin
            mf_pos_next = 8'd0;
            mf_num_next = 2'd0;
        end
        if (state_next == ST_INIT) begin
            err_next   = 2'd0;
            clean_next = 2'd0;
        end
    end

    assign keep_link = (state_next != ST_INIT);

    // Character restore: F<=DATA_PATH_WIDTH keeps the frame aligned to the
    // beat (fpos stays 0), larger F advances fpos one beat at a time.
    assign small_f   = cfg_octets_per_frame < 8'(DATA_PATH_WIDTH);
    assign fpos_next = (small_f || ({1'b0, fpos} + 9'(DATA_PATH_WIDTH) > {1'b0, cfg_octets_per_frame}))
                       ? 8'd0 : fpos + 8'(DATA_PATH_WIDTH);

    always_comb begin
        logic       eof;
        logic [7:0] oct;
        rest_data = phy.phy_data;
        eof_run   = last_eof;
        for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
            oct = phy.phy_data[8*i +: 8];
            eof = small_f ? ((8'(i) & cfg_octets_per_frame) == cfg_octets_per_frame)
                          : ((fpos + 8'(i)) == cfg_octets_per_frame);
            if (eof) begin
                if (phy.phy_charisk[i] && ((oct == 8'hFC) || (oct == 8'h7C)))
                    rest_data[8*i +: 8] = eof_run;
                else
                    eof_run = oct;
            end
        end
    end

    assign scr_w     = octet_swap(phy.phy_data);
    assign desc_data = octet_swap(descramble(scr_w, scr_state));

    // Stage 0: classify and transform the PHY beat
    always_ff @(posedge clk) begin
        ilas_data_p0 <= phy.phy_data;
        rx_data_p0   <= cfg_disable_scrambler ? rest_data : desc_data;
    end

    // Stage 1: output registers, cut the same cycle the link falls to INIT
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_INIT;
            k_cnt         <= 2'd0;
            err_cnt       <= 2'd0;
            clean_cnt     <= 2'd0;
            mf_pos        <= 8'd0;
            mf_num        <= 2'd0;
            scr_state     <= 15'd0;
            fpos          <= 8'd0;
            last_eof      <= 8'd0;
            vld_ilas_p0   <= 1'b0;
            vld_data_p0   <= 1'b0;
            ilas_valid    <= 1'b0;
            rx_valid      <= 1'b0;
            ilas_data     <= '0;
            rx_data       <= '0;
            status_resync <= 1'b0;
        end else begin
            state     <= state_next;
            k_cnt     <= k_cnt_next;
            err_cnt   <= err_next;
            clean_cnt <= clean_next;
            mf_pos    <= mf_pos_next;
            mf_num    <= mf_num_next;
            if (state == ST_DATA) begin
                scr_state <= scr_w[14:0];
                fpos      <= fpos_next;
                last_eof  <= eof_run;
            end else begin
                scr_state <= 15'd0;
                fpos      <= 8'd0;
                last_eof  <= 8'd0;
            end
            vld_ilas_p0   <= ilas_beat && keep_link;
            vld_data_p0   <= data_beat && keep_link;
            ilas_valid    <= vld_ilas_p0 && keep_link;
            rx_valid      <= vld_data_p0 && keep_link;
            if (vld_ilas_p0)
                ilas_data <= ilas_data_p0;
            if (vld_data_p0)
                rx_data <= rx_data_p0;
            status_resync <= (state != ST_INIT) && !keep_link;
        end
    end

    assign status_state = state;

`ifdef JESD204_RX_LANE_ERR_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [7:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {25'd0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [7:0] err_octets;

    always_comb begin
        err_octets = 8'd0;
        for (int i = 0; i < DATA_PATH_WIDTH; i++)
            err_octets = err_octets + {7'd0, oct_err[i]};
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            status_err_count <= 32'd0;
        else
            status_err_count <= sat_add(status_err_count, err_octets);
    end
`endif

endmodule
